// File: rtl/aurora_link_manager.sv
// Reset sequencer and link supervisor for a multi-lane Aurora core: drives the
// reset_pb/pma_init power-up sequence, watches channel/lane status, retries, and parks in FAIL.
module aurora_link_manager #(
  parameter int NUM_LANES         = 4,
  parameter int SIMULATION        = 0,
  parameter int PB_LEAD_CYCLES    = 128,
  parameter int PMA_INIT_CYCLES   = 1 << 20,
  parameter int PB_TRAIL_CYCLES   = 128,
  parameter int UP_TIMEOUT_CYCLES = 1 << 24,
  parameter int DROP_CYCLES       = 16,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sw_reset,
  input  logic                             sys_reset_out,
  input  logic                             gt_pll_lock,
  input  logic                             channel_up,
  input  logic [NUM_LANES-1:0]             lane_up,
  output logic                             reset_pb,
  output logic                             pma_init,
  output logic                             link_ok,
  output logic [$clog2(NUM_LANES+1)-1:0]   lanes_up_count,
  output logic [7:0]                       retry_total,
  output logic                             fail,
  output logic [2:0]                       state
);

  localparam int LEAD_LD  = (SIMULATION != 0) ? 16 : PB_LEAD_CYCLES;
  localparam int PMA_LD   = (SIMULATION != 0) ? 16 : PMA_INIT_CYCLES;
  localparam int TRAIL_LD = (SIMULATION != 0) ? 16 : PB_TRAIL_CYCLES;
  localparam int UP_LD    = (SIMULATION != 0) ? 16 : UP_TIMEOUT_CYCLES;
  localparam int MAX_A    = (LEAD_LD > PMA_LD) ? LEAD_LD : PMA_LD;
  localparam int MAX_B    = (TRAIL_LD > UP_LD) ? TRAIL_LD : UP_LD;
  localparam int MAX_LD   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W    = $clog2(MAX_LD + 1);
  localparam int FC_W     = $clog2(MAX_RETRIES + 1);
  localparam int DROP_W   = $clog2(DROP_CYCLES + 1);
  localparam int CNT_W    = $clog2(NUM_LANES + 1);

  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(MAX_RETRIES - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PB_LEAD  = 3'd0,
    S_PMA      = 3'd1,
    S_PB_TRAIL = 3'd2,
    S_WAIT_UP  = 3'd3,
    S_LINK_UP  = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  state_t              cur;
  state_t              nxt;
  logic [TMR_W-1:0]    timer;
  logic [FC_W-1:0]     fail_cnt;
  logic [DROP_W-1:0]   drop_cnt;
  logic                sw_q1;
  logic                sw_q2;
  logic                sw_edge;
  logic                up_cond;
  logic                tmr_done;
  logic                timeout;
  logic                drop_hit;

  function automatic logic [TMR_W-1:0] load_for(input state_t s);
    case (s)
      S_PB_LEAD:  return TMR_W'(LEAD_LD);
      S_PMA:      return TMR_W'(PMA_LD);
      S_PB_TRAIL: return TMR_W'(TRAIL_LD);
      S_WAIT_UP:  return TMR_W'(UP_LD);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) sum = sum + CNT_W'(v[i]);
    return sum;
  endfunction

  assign state    = cur;
  assign sw_edge  = sw_q1 & ~sw_q2;
  assign up_cond  = channel_up & gt_pll_lock & ~sys_reset_out;
  assign tmr_done = (timer == TMR_W'(1));
  assign timeout  = (cur == S_WAIT_UP) && tmr_done && !up_cond;
  assign drop_hit = (cur == S_LINK_UP) && !channel_up && (drop_cnt == DROP_LAST);

  always_comb begin
    nxt = cur;
    if (sw_edge) begin
      nxt = S_PB_LEAD;
    end else begin
      case (cur)
        S_PB_LEAD:  if (tmr_done) nxt = S_PMA;
        S_PMA:      if (tmr_done) nxt = S_PB_TRAIL;
        S_PB_TRAIL: if (tmr_done) nxt = S_WAIT_UP;
        S_WAIT_UP: begin
          if (up_cond)       nxt = S_LINK_UP;
          else if (tmr_done) nxt = (fail_cnt == FC_LAST) ? S_FAIL : S_PB_LEAD;
        end
        S_LINK_UP:  if (drop_hit) nxt = S_PB_LEAD;
        default:    nxt = cur;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur            <= S_PB_LEAD;
      timer          <= '0;
      fail_cnt       <= '0;
      drop_cnt       <= '0;
      sw_q1          <= 1'b0;
      sw_q2          <= 1'b0;
      reset_pb       <= 1'b1;
      pma_init       <= 1'b0;
      link_ok        <= 1'b0;
      fail           <= 1'b0;
      lanes_up_count <= '0;
      retry_total    <= '0;
    end else begin
      sw_q1 <= sw_reset;
      sw_q2 <= sw_q1;
      cur   <= nxt;

      // Coming out of rst the timer is still 0, so the first PB_LEAD cycle loads it.
      if (sw_edge || (nxt != cur))
        timer <= load_for(nxt);
      else if ((cur == S_PB_LEAD) && (timer == '0))
        timer <= TMR_W'(LEAD_LD);
      else if (timer != '0)
        timer <= timer - TMR_W'(1);

      if (sw_edge || ((nxt == S_LINK_UP) && (cur != S_LINK_UP)))
        fail_cnt <= '0;
      else if (timeout)
        fail_cnt <= fail_cnt + FC_W'(1);

      if ((cur == S_LINK_UP) && !channel_up && !sw_edge && !drop_hit)
        drop_cnt <= drop_cnt + DROP_W'(1);
      else
        drop_cnt <= '0;

      if (!sw_edge && (timeout || drop_hit) && (retry_total != 8'hFF))
        retry_total <= retry_total + 8'd1;

      reset_pb       <= (nxt != S_WAIT_UP) && (nxt != S_LINK_UP);
      pma_init       <= (nxt == S_PMA);
      fail           <= (nxt == S_FAIL);
      link_ok        <= (nxt == S_LINK_UP) && (&lane_up);
      lanes_up_count <= popcount(lane_up);
    end
  end

endmodule

// File: tb/tb_aurora_link_manager.sv
// Self-checking bench for aurora_link_manager: randomized and directed stimulus
// compared against a phase/elapsed-time reference model.
module tb_aurora_link_manager;

  localparam int LEAD  = 4;
  localparam int PMA   = 8;
  localparam int TRAIL = 4;
  localparam int TO    = 100;
  localparam int DROP  = 16;
  localparam int MAXR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_sim = 1'b1;
  logic       sw_reset = 1'b0;
  logic       sys_reset_out = 1'b0;
  logic       gt_pll_lock = 1'b0;
  logic       channel_up = 1'b0;
  logic [3:0] lane_up = 4'h0;

  logic       reset_pb, pma_init, link_ok, fail;
  logic [2:0] lanes_up_count, state;
  logic [7:0] retry_total;
  logic       s_reset_pb, s_pma_init, s_link_ok, s_fail;
  logic [2:0] s_cnt, s_state;
  logic [7:0] s_retry;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase code, edge of entry, cycle index, counters
  int m_ph, m_ent, m_cyc, m_fails, m_retry, m_lows, m_cnt;
  bit m_s1, m_s2, m_lok;

  always #5 clk = ~clk;

  aurora_link_manager #(
    .NUM_LANES(4), .SIMULATION(0), .PB_LEAD_CYCLES(LEAD), .PMA_INIT_CYCLES(PMA),
    .PB_TRAIL_CYCLES(TRAIL), .UP_TIMEOUT_CYCLES(TO), .DROP_CYCLES(DROP), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .sw_reset(sw_reset), .sys_reset_out(sys_reset_out),
    .gt_pll_lock(gt_pll_lock), .channel_up(channel_up), .lane_up(lane_up),
    .reset_pb(reset_pb), .pma_init(pma_init), .link_ok(link_ok),
    .lanes_up_count(lanes_up_count), .retry_total(retry_total), .fail(fail), .state(state)
  );

  aurora_link_manager #(
    .NUM_LANES(4), .SIMULATION(1), .PB_LEAD_CYCLES(3), .PMA_INIT_CYCLES(5),
    .PB_TRAIL_CYCLES(7), .UP_TIMEOUT_CYCLES(100), .DROP_CYCLES(DROP), .MAX_RETRIES(MAXR)
  ) dut_sim (
    .clk(clk), .rst(rst_sim), .sw_reset(sw_reset), .sys_reset_out(sys_reset_out),
    .gt_pll_lock(gt_pll_lock), .channel_up(channel_up), .lane_up(lane_up),
    .reset_pb(s_reset_pb), .pma_init(s_pma_init), .link_ok(s_link_ok),
    .lanes_up_count(s_cnt), .retry_total(s_retry), .fail(s_fail), .state(s_state)
  );

  logic [17:0] obs;
  assign obs = {state, reset_pb, pma_init, link_ok, lanes_up_count, retry_total, fail};

  function automatic logic [17:0] exp_vec();
    return {3'(m_ph), (m_ph != 3) && (m_ph != 4), m_ph == 1, m_lok, 3'(m_cnt), 8'(m_retry), m_ph == 5};
  endfunction

  function automatic int dur(input int ph);
    case (ph)
      0:       return LEAD;
      1:       return PMA;
      2:       return TRAIL;
      default: return TO;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ent = 0; m_cyc = -1; m_fails = 0; m_retry = 0; m_lows = 0;
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_lok = 0;
  endtask

  task automatic model_step();
    int  nph;
    bit  swe;
    m_cyc++;
    swe  = m_s1 && !m_s2;
    m_s2 = m_s1;
    m_s1 = sw_reset;
    nph  = m_ph;
    if (swe) begin
      nph = 0;
      m_fails = 0;
    end else begin
      case (m_ph)
        0, 1, 2: if (m_cyc == m_ent + dur(m_ph)) nph = m_ph + 1;
        3: begin
          if (channel_up && gt_pll_lock && !sys_reset_out) nph = 4;
          else if (m_cyc == m_ent + TO) begin
            m_fails++;
            if (m_retry < 255) m_retry++;
            nph = (m_fails == MAXR) ? 5 : 0;
          end
        end
        4: begin
          m_lows = channel_up ? 0 : m_lows + 1;
          if (m_lows == DROP) begin
            if (m_retry < 255) m_retry++;
            nph = 0;
          end
        end
        default: ;
      endcase
    end
    if (swe || nph != m_ph) begin
      m_ent  = m_cyc;
      m_lows = 0;
      if (nph == 4) m_fails = 0;
    end
    m_ph  = nph;
    m_lok = (m_ph == 4) && (lane_up == 4'hF);
    m_cnt = $countones(lane_up);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    channel_up = 1; gt_pll_lock = 1; lane_up = 4'hF; sys_reset_out = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 18'b000_1_0_0_000_00000000_0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, 18'b000_1_0_0_000_00000000_0);
    end
    n_checks++;
    if ({s_state, s_reset_pb, s_pma_init, s_fail} !== 6'b000_1_0_0) begin
      n_fail++; $display("FAIL reset_values_sim got=%b exp=000100", {s_state, s_reset_pb, s_pma_init, s_fail});
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    for (int i = 0; i < 25; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL powerup_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
      if (m_cyc == 3 || m_cyc == 12) begin
        n_checks++;
        if (pma_init !== 1'b0) begin n_fail++; $display("FAIL pma_low cyc=%0d got=%b exp=0", m_cyc, pma_init); end
      end
      if (m_cyc == 4 || m_cyc == 11) begin
        n_checks++;
        if (pma_init !== 1'b1) begin n_fail++; $display("FAIL pma_high cyc=%0d got=%b exp=1", m_cyc, pma_init); end
      end
      if (m_cyc == 15 || m_cyc == 16) begin
        n_checks++;
        if (reset_pb !== (m_cyc == 15)) begin n_fail++; $display("FAIL reset_pb_fall cyc=%0d got=%b", m_cyc, reset_pb); end
      end
      if (m_cyc == 18) begin
        n_checks++;
        if ({link_ok, lanes_up_count} !== 4'b1_100) begin
          n_fail++; $display("FAIL link_ok_up cyc=%0d got=%b%0d exp=1 4", m_cyc, link_ok, lanes_up_count);
        end
      end
    end
  endtask

  task automatic test_lanes();
    lane_up = 4'b1011;
    cycle();
    n_checks++;
    if ({state, link_ok, lanes_up_count} !== {3'd4, 1'b0, 3'd3}) begin
      n_fail++; $display("FAIL lanes_1011 got=%0d/%b/%0d exp=4/0/3", state, link_ok, lanes_up_count);
    end
    for (int i = 0; i < 20; i++) begin
      lane_up = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL lanes_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
    end
    lane_up = 4'hF;
    cycle();
  endtask

  task automatic test_drop();
    for (int i = 0; i < 16 + 16 + 20; i++) begin
      channel_up = (i < 15) ? 1'b0 : (i == 15) ? 1'b1 : (i < 32) ? 1'b0 : 1'b1;
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL drop_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
      if (i == 15) begin
        n_checks++;
        if (state !== 3'd4) begin n_fail++; $display("FAIL drop_15_no_restart got=%0d exp=4", state); end
      end
      if (i == 31) begin
        n_checks++;
        if ({state, retry_total} !== {3'd0, 8'd1}) begin
          n_fail++; $display("FAIL drop_16_restart got=%0d/%0d exp=0/1", state, retry_total);
        end
      end
    end
  endtask

  task automatic test_timeout_fail();
    apply_reset();
    channel_up = 0;
    for (int i = 0; i < 240; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
      if (m_cyc == 116) begin
        n_checks++;
        if ({state, retry_total} !== {3'd0, 8'd1}) begin
          n_fail++; $display("FAIL first_timeout got=%0d/%0d exp=0/1", state, retry_total);
        end
      end
      if (m_cyc == 232) begin
        n_checks++;
        if ({state, fail, retry_total, reset_pb} !== {3'd5, 1'b1, 8'd2, 1'b1}) begin
          n_fail++; $display("FAIL enter_fail got=%0d/%b/%0d/%b exp=5/1/2/1", state, fail, retry_total, reset_pb);
        end
      end
    end
    sw_reset = 1;
    cycle();
    sw_reset = 0;
    n_checks++;
    if (state !== 3'd5) begin n_fail++; $display("FAIL sw_latency got=%0d exp=5", state); end
    cycle();
    n_checks++;
    if ({state, fail, retry_total, reset_pb} !== {3'd0, 1'b0, 8'd2, 1'b1}) begin
      n_fail++; $display("FAIL sw_from_fail got=%0d/%b/%0d/%b exp=0/0/2/1", state, fail, retry_total, reset_pb);
    end
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL restart_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_sw_vs_timeout();
    apply_reset();
    channel_up = 0;
    while (m_cyc < 240) begin
      sw_reset = (m_cyc == 114);
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL swvt_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
      if (m_cyc == 116) begin
        n_checks++;
        if ({state, retry_total} !== {3'd0, 8'd0}) begin
          n_fail++; $display("FAIL sw_beats_timeout got=%0d/%0d exp=0/0", state, retry_total);
        end
      end
      if (m_cyc == 232) begin
        n_checks++;
        if ({state, retry_total} !== {3'd0, 8'd1}) begin
          n_fail++; $display("FAIL sw_cleared_fail_cnt got=%0d/%0d exp=0/1", state, retry_total);
        end
      end
    end
    sw_reset = 0;
  endtask

  task automatic test_up_vs_timeout();
    apply_reset();
    channel_up = 0;
    while (m_cyc < 116) begin
      channel_up = (m_cyc == 115);
      cycle();
    end
    n_checks++;
    if ({state, retry_total, link_ok} !== {3'd4, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL up_beats_timeout got=%0d/%0d/%b exp=4/0/1", state, retry_total, link_ok);
    end
  endtask

  task automatic test_rst_mid_pma();
    apply_reset();
    while (m_cyc < 7) cycle();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({state, reset_pb, pma_init} !== {3'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rst_async got=%0d/%b/%b exp=0/1/0", state, reset_pb, pma_init);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL rst_restart_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
      if (m_cyc == 3 || m_cyc == 4) begin
        n_checks++;
        if (pma_init !== (m_cyc == 4)) begin n_fail++; $display("FAIL rst_restart_pma cyc=%0d got=%b", m_cyc, pma_init); end
      end
    end
  endtask

  task automatic test_random();
    int mode;
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      mode = (i / 250) % 3;
      channel_up    = (mode == 0) ? ($urandom_range(0, 9) != 0) :
                      (mode == 1) ? ($urandom_range(0, 49) == 0) : 1'($urandom_range(0, 1));
      gt_pll_lock   = ($urandom_range(0, 19) != 0);
      sys_reset_out = ($urandom_range(0, 19) == 0);
      lane_up       = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      sw_reset      = ($urandom_range(0, 199) == 0);
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", m_cyc, obs, exp_vec()); end
    end
    sw_reset = 0;
  endtask

  task automatic test_simulation();
    channel_up = 0;
    sw_reset   = 0;
    rst_sim    = 1'b0;
    for (int k = 0; k <= 66; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 15 || k == 32) begin
        n_checks++;
        if (s_pma_init !== 1'b0) begin n_fail++; $display("FAIL sim_pma_low k=%0d got=%b exp=0", k, s_pma_init); end
      end
      if (k == 16 || k == 31) begin
        n_checks++;
        if (s_pma_init !== 1'b1) begin n_fail++; $display("FAIL sim_pma_high k=%0d got=%b exp=1", k, s_pma_init); end
      end
      if (k == 47 || k == 48) begin
        n_checks++;
        if (s_reset_pb !== (k == 47)) begin n_fail++; $display("FAIL sim_reset_pb k=%0d got=%b", k, s_reset_pb); end
      end
      if (k == 63 || k == 64) begin
        n_checks++;
        if ({s_state, s_retry} !== ((k == 63) ? {3'd3, 8'd0} : {3'd0, 8'd1})) begin
          n_fail++; $display("FAIL sim_timeout k=%0d got=%0d/%0d", k, s_state, s_retry);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lanes();
    test_drop();
    test_timeout_fail();
    test_sw_vs_timeout();
    test_up_vs_timeout();
    test_rst_mid_pma();
    test_random();
    test_simulation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_link_manager.md
# aurora_link_manager

Parametrised reset sequencer and link supervisor for multi-lane Aurora cores. It drives the core's `reset_pb`/`pma_init` power-up sequence and watches `channel_up`, lane status and GT PLL lock. On timeout or link drop it retries the sequence, and after a configurable number of consecutive failures it parks in a sticky fail state. It sits between the block's control registers and the Aurora IP, runs in the `init_clk` domain, and supersedes the fixed single-shot reset FSM.

## Interface

Parameters:
- `NUM_LANES`, 4: number of Aurora lanes; width of `lane_up`.
- `SIMULATION`, 0: when 1, every timer load below is replaced by 16.
- `PB_LEAD_CYCLES`, 128: cycles `reset_pb` is high before `pma_init` rises.
- `PMA_INIT_CYCLES`, 2^20: cycles `pma_init` is held high.
- `PB_TRAIL_CYCLES`, 128: cycles `reset_pb` stays high after `pma_init` falls.
- `UP_TIMEOUT_CYCLES`, 2^24: maximum cycles in WAIT_UP before a failure is declared.
- `DROP_CYCLES`, 16: consecutive cycles of `channel_up`=0 in LINK_UP that count as a drop.
- `MAX_RETRIES`, 3: consecutive WAIT_UP timeouts that lead to FAIL (≥1).

Ports:
- `clk`  in  1  `init_clk`-domain clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sw_reset`  in  1  software restart request; the rising edge is acted on.
- `sys_reset_out`  in  1  core system reset, already synchronised to `clk`.
- `gt_pll_lock`  in  1  GT PLL lock.
- `channel_up`  in  1  Aurora channel up, already synchronised.
- `lane_up`  in  NUM_LANES  per-lane up, already synchronised.
- `reset_pb`  out  1  to core `reset_pb`.
- `pma_init`  out  1  to core `pma_init`.
- `link_ok`  out  1  high in LINK_UP while all `lane_up` bits are 1.
- `lanes_up_count`  out  $clog2(NUM_LANES+1)  popcount of `lane_up`, registered.
- `retry_total`  out  8  total automatic restarts, saturating at 255.
- `fail`  out  1  high in FAIL.
- `state`  out  3  0 PB_LEAD, 1 PMA, 2 PB_TRAIL, 3 WAIT_UP, 4 LINK_UP, 5 FAIL.

## Operation

- All outputs are registered and decoded from state.
- Reset values: state=PB_LEAD, `reset_pb`=1, `pma_init`=0, `link_ok`=0, `lanes_up_count`=0, `retry_total`=0, `fail`=0. The internal consecutive-fail counter (`fail_cnt`) and the timer are 0.
- Per-state outputs:
  - PB_LEAD: `reset_pb`=1, `pma_init`=0. After PB_LEAD_CYCLES go to PMA.
  - PMA: `reset_pb`=1, `pma_init`=1. After PMA_INIT_CYCLES go to PB_TRAIL.
  - PB_TRAIL: `reset_pb`=1, `pma_init`=0. After PB_TRAIL_CYCLES go to WAIT_UP and load the timeout timer.
  - WAIT_UP: `reset_pb`=0. Go to LINK_UP when `channel_up`, `gt_pll_lock` and `!sys_reset_out` are all true in the same cycle.
- WAIT_UP timeout: UP_TIMEOUT_CYCLES elapse without the LINK_UP condition. Then `fail_cnt`++ and `retry_total`++ (saturating).
  - If the new `fail_cnt` equals MAX_RETRIES, go to FAIL.
  - Otherwise go to PB_LEAD.
- LINK_UP: `fail_cnt` clears on entry. If `channel_up` is low for DROP_CYCLES consecutive cycles, `retry_total`++ and go to PB_LEAD. `fail_cnt` is not incremented. Any high cycle clears the drop counter.
- FAIL: `reset_pb`=1, `pma_init`=0, `fail`=1. Held until a `sw_reset` edge or `rst`.
- `sw_reset` rising edge, in any state: go to PB_LEAD, clear `fail_cnt`, clear the drop counter. `retry_total` is unchanged and not incremented.
- Simultaneous events: a `sw_reset` edge beats a timeout or drop in the same cycle. A timeout and the LINK_UP condition in the same cycle resolve to LINK_UP.
- `rst` asserted mid-sequence returns every register to its reset value immediately (asynchronous).
- The timer is a down-counter sized to $clog2 of the largest load. A load of N gives exactly N cycles in the state.

## Timing

- Cycle 0 is the first rising edge with `rst` low.
- `pma_init` rises after exactly PB_LEAD_CYCLES cycles with `reset_pb` high.
- `pma_init` is high for exactly PMA_INIT_CYCLES cycles.
- `reset_pb` falls exactly PB_TRAIL_CYCLES cycles after `pma_init` falls.
- Input-to-state latency is 1 cycle. `link_ok` asserts 1 cycle after the LINK_UP condition and falls 1 cycle after any `lane_up` bit drops.
- `lanes_up_count` lags `lane_up` by 1 cycle.
- `sw_reset` edge detection adds 1 cycle: `reset_pb` is 1 on the second edge after the `sw_reset` rise.

## Test plan

All scenarios use PB_LEAD=4, PMA_INIT=8, PB_TRAIL=4, UP_TIMEOUT=100, DROP=16, MAX_RETRIES=2 unless noted.

- Power-up, with `channel_up`, `gt_pll_lock` and all lanes high and `sys_reset_out`=0 from the start -> `pma_init` high for cycles 4–11, `reset_pb` falls at cycle 16, `link_ok`=1 by cycle 18, `lanes_up_count`=4.
- `channel_up` held 0 -> timeout at WAIT_UP+100 and restart with `retry_total`=1; second timeout -> `state`=5, `fail`=1, `retry_total`=2, `reset_pb`=1. A `sw_reset` pulse then restarts the sequence with `fail`=0 and `retry_total` still 2.
- In LINK_UP, `channel_up` low for 15 cycles then high -> no restart. Low for 16 cycles -> PB_LEAD, `retry_total`=1, `fail_cnt` unchanged.
- `lane_up`=4'b1011 while `channel_up`=1 -> `link_ok`=0, `lanes_up_count`=3.
- `sw_reset` edge in the same cycle as the WAIT_UP timeout -> PB_LEAD, `retry_total` not incremented. `rst` pulse during PMA -> `pma_init`=0 immediately and the sequence restarts from cycle 0.
- SIMULATION=1 -> every phase lasts exactly 16 cycles regardless of the parameter values.
